shot_pool: RTL and testbench

Manages a pool of up to `NUM_SHOTS` player shots and renders them. It sits directly downstream of the 16x16 shot bitmap: it consumes that bitmap's `object_colors` array and produces a per-pixel draw request and an RGB332 colour for the video mux. It also accepts fire requests, moves shots upward once per frame, and retires shots that leave the screen or are cleared by collision logic.

---
 rtl/shot_pool_if.sv | 21 ++
 rtl/shot_pool.sv | 146 ++++++++++++++
 tb/tb_shot_pool.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/shot_pool_if.sv
// Fire/kill handshake bundle between the game controller (master) and shot_pool (slave).
interface shot_pool_if #(
  parameter int unsigned NUM_SHOTS = 4
) ();
  logic                 fire_req;
  logic [10:0]          fire_x;
  logic [10:0]          fire_y;
  logic                 fire_ack;
  logic [NUM_SHOTS-1:0] hit_clear;
  logic [NUM_SHOTS-1:0] active_mask;

  modport master (
    output fire_req, fire_x, fire_y, hit_clear,
    input  fire_ack, active_mask
  );

  modport slave (
    input  fire_req, fire_x, fire_y, hit_clear,
    output fire_ack, active_mask
  );
endinterface

// File: rtl/shot_pool.sv
// Pool of player shots: fire/move/retire per slot and 1-cycle registered renderer.
// Optional fire cooldown counter enabled by defining SHOT_COOLDOWN_EN.
module shot_pool #(
  parameter int unsigned NUM_SHOTS     = 4,
  parameter int unsigned SHOT_SPEED    = 4,
  parameter int unsigned FIRE_COOLDOWN = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startOfFrame,
  shot_pool_if.slave       shot_if,
  input  logic [10:0]      pixelX,
  input  logic [10:0]      pixelY,
  input  logic [7:0]       object_colors [0:15][0:15],
  output logic             drawingRequest,
  output logic [7:0]       RGBout
);

  localparam logic [10:0] Speed = 11'(SHOT_SPEED);

  logic [NUM_SHOTS-1:0] valid_q, valid_d;
  logic [10:0]          x_q [NUM_SHOTS];
  logic [10:0]          x_d [NUM_SHOTS];
  logic [10:0]          y_q [NUM_SHOTS];
  logic [10:0]          y_d [NUM_SHOTS];
  logic                 fire_ack_q, fire_ack_d;
  logic                 draw_q, draw_d;
  logic [7:0]           rgb_q, rgb_d;

  logic [NUM_SHOTS-1:0] free;
  logic [NUM_SHOTS-1:0] load_oh;
  logic                 found;
  logic                 cool_ok;
  logic                 fire_ok;

`ifdef SHOT_COOLDOWN_EN
  localparam logic [7:0] CoolInit = 8'(FIRE_COOLDOWN);
  logic [7:0] cooldown_q, cooldown_d;

  assign cool_ok = (cooldown_q == 8'd0);

  always_comb begin
    cooldown_d = cooldown_q;
    if (fire_ok) begin
      cooldown_d = CoolInit;
    end else if (startOfFrame && cooldown_q != 8'd0) begin
      cooldown_d = cooldown_q - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cooldown_q <= 8'd0;
    else       cooldown_q <= cooldown_d;
  end
`else
  assign cool_ok = 1'b1;
`endif

  // A slot being killed this cycle is not reusable until the next one.
  assign free = ~valid_q & ~shot_if.hit_clear;

  always_comb begin
    load_oh = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (free[i] && !found) begin
        load_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign fire_ok    = shot_if.fire_req && cool_ok && (|free);
  assign fire_ack_d = fire_ok;

  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (shot_if.hit_clear[i]) begin
        valid_d[i] = 1'b0;
      end else if (startOfFrame && valid_q[i]) begin
        if (y_q[i] < Speed) valid_d[i] = 1'b0;
        else                y_d[i]     = y_q[i] - Speed;
      end else if (fire_ok && load_oh[i]) begin
        valid_d[i] = 1'b1;
        x_d[i]     = shot_if.fire_x;
        y_d[i]     = shot_if.fire_y;
      end
    end
  end

  logic [10:0]          dx [NUM_SHOTS];
  logic [10:0]          dy [NUM_SHOTS];
  logic [7:0]           sample [NUM_SHOTS];
  logic [NUM_SHOTS-1:0] hit;

  // Compare-then-subtract form keeps shots near x=2047 from wrapping to the left edge.
  always_comb begin
    for (int i = 0; i < NUM_SHOTS; i++) begin
      dx[i]     = pixelX - x_q[i];
      dy[i]     = pixelY - y_q[i];
      sample[i] = object_colors[dy[i][3:0]][dx[i][3:0]];
      hit[i]    = valid_q[i] && (pixelX >= x_q[i]) && (dx[i] < 11'd16) &&
                  (pixelY >= y_q[i]) && (dy[i] < 11'd16) && (sample[i] != 8'hFF);
    end
  end

  always_comb begin
    draw_d = 1'b0;
    rgb_d  = 8'hFF;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        draw_d = 1'b1;
        rgb_d  = sample[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      fire_ack_q <= 1'b0;
      draw_q     <= 1'b0;
      rgb_q      <= 8'hFF;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        x_q[i] <= 11'd0;
        y_q[i] <= 11'd0;
      end
    end else begin
      valid_q    <= valid_d;
      x_q        <= x_d;
      y_q        <= y_d;
      fire_ack_q <= fire_ack_d;
      draw_q     <= draw_d;
      rgb_q      <= rgb_d;
    end
  end

  assign shot_if.fire_ack    = fire_ack_q;
  assign shot_if.active_mask = valid_q;
  assign drawingRequest      = draw_q;
  assign RGBout              = rgb_q;

endmodule

// File: tb/tb_shot_pool.sv
// Directed self-checking bench for shot_pool (4 slots, speed 4).
module tb_shot_pool;

  logic        clk = 1'b0;
  logic        reset;
  logic        sof;
  logic [10:0] px, py;
  logic [7:0]  obj [0:15][0:15];
  logic        draw;
  logic [7:0]  rgb;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  shot_pool_if #(.NUM_SHOTS(4)) sif ();

`ifdef SHOT_COOLDOWN_EN
  localparam int unsigned MainCool = 0;
`else
  localparam int unsigned MainCool = 2;
`endif

  shot_pool #(.NUM_SHOTS(4), .SHOT_SPEED(4), .FIRE_COOLDOWN(MainCool)) dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (sof),
    .shot_if        (sif),
    .pixelX         (px),
    .pixelY         (py),
    .object_colors  (obj),
    .drawingRequest (draw),
    .RGBout         (rgb)
  );

`ifdef SHOT_COOLDOWN_EN
  shot_pool_if #(.NUM_SHOTS(4)) cif ();
  logic       cd_draw;
  logic [7:0] cd_rgb;

  shot_pool #(.NUM_SHOTS(4), .SHOT_SPEED(4), .FIRE_COOLDOWN(2)) dut_cd (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (sof),
    .shot_if        (cif),
    .pixelX         (px),
    .pixelY         (py),
    .object_colors  (obj),
    .drawingRequest (cd_draw),
    .RGBout         (cd_rgb)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic exp_d, input logic [7:0] exp_c,
                     input string tag);
    px = 11'(x);
    py = 11'(y);
    tick();
    check({tag, "_draw"}, 32'(draw), 32'(exp_d));
    check({tag, "_rgb"}, 32'(rgb), 32'(exp_c));
  endtask

  task automatic fire(input int x, input int y, input logic [3:0] exp_mask, input string tag);
    sif.fire_req = 1'b1;
    sif.fire_x   = 11'(x);
    sif.fire_y   = 11'(y);
    tick();
    sif.fire_req = 1'b0;
    check({tag, "_ack"}, 32'(sif.fire_ack), 32'd1);
    check({tag, "_mask"}, 32'(sif.active_mask), 32'(exp_mask));
  endtask

  initial begin
    // Column 0 transparent; otherwise {col+8, row}, so row 0 col 7 is F0.
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        obj[r][c] = (c == 0) ? 8'hFF : {4'(c + 8), 4'(r)};
      end
    end
    reset = 1'b1;
    sof = 1'b0;
    px = '0;
    py = '0;
    sif.fire_req = 1'b0;
    sif.fire_x = '0;
    sif.fire_y = '0;
    sif.hit_clear = '0;
`ifdef SHOT_COOLDOWN_EN
    cif.fire_req = 1'b0;
    cif.fire_x = '0;
    cif.fire_y = '0;
    cif.hit_clear = '0;
`endif
    tick();
    tick();
    check("rst_draw", 32'(draw), 32'd0);
    check("rst_rgb", 32'(rgb), 32'hFF);
    check("rst_mask", 32'(sif.active_mask), 32'd0);
    check("rst_ack", 32'(sif.fire_ack), 32'd0);
    reset = 1'b0;

    // Idle sweep
    for (int y = 0; y < 2048; y += 127) begin
      for (int x = 0; x < 2048; x += 89) begin
        pix(x, y, 1'b0, 8'hFF, "idle");
      end
    end
    check("idle_mask", 32'(sif.active_mask), 32'd0);

    // Fire and render
    fire(100, 200, 4'b0001, "fire0");
    tick();
    check("ack_pulse", 32'(sif.fire_ack), 32'd0);
    pix(107, 200, 1'b1, 8'hF0, "r107");
    pix(100, 200, 1'b0, 8'hFF, "r100");
    pix(116, 200, 1'b0, 8'hFF, "r116");
    pix(115, 215, 1'b1, 8'h7F, "r115_215");

    // Overlap priority
    fire(102, 200, 4'b0011, "fire1");
    pix(107, 200, 1'b1, 8'hF0, "prio");
    pix(101, 200, 1'b1, 8'h90, "prio101");

    // Mid-state reset, then fill the pool with fire_req held
    #3 reset = 1'b1;
    #1 check("rst2_mask", 32'(sif.active_mask), 32'd0);
    tick();
    reset = 1'b0;
    sif.fire_req = 1'b1;
    sif.fire_x = 11'd300;
    sif.fire_y = 11'd300;
    tick(); check("fill1_ack", 32'(sif.fire_ack), 32'd1);
    check("fill1_mask", 32'(sif.active_mask), 32'b0001);
    tick(); check("fill2_ack", 32'(sif.fire_ack), 32'd1);
    check("fill2_mask", 32'(sif.active_mask), 32'b0011);
    tick(); check("fill3_ack", 32'(sif.fire_ack), 32'd1);
    check("fill3_mask", 32'(sif.active_mask), 32'b0111);
    tick(); check("fill4_ack", 32'(sif.fire_ack), 32'd1);
    check("fill4_mask", 32'(sif.active_mask), 32'b1111);
    tick(); check("full_ack", 32'(sif.fire_ack), 32'd0);
    check("full_mask", 32'(sif.active_mask), 32'b1111);

    // Kill slot 0 while firing: not free this cycle, reused next cycle
    sif.hit_clear = 4'b0001;
    sif.fire_x = 11'd600;
    sif.fire_y = 11'd600;
    tick(); check("kill_ack", 32'(sif.fire_ack), 32'd0);
    check("kill_mask", 32'(sif.active_mask), 32'b1110);
    sif.hit_clear = 4'b0000;
    tick(); check("reuse_ack", 32'(sif.fire_ack), 32'd1);
    check("reuse_mask", 32'(sif.active_mask), 32'b1111);
    sif.fire_req = 1'b0;
    pix(607, 600, 1'b1, 8'hF0, "reuse_r");

    // hit_clear coincident with startOfFrame
    sif.hit_clear = 4'b0010;
    sof = 1'b1;
    tick(); check("hitsof_mask", 32'(sif.active_mask), 32'b1101);
    sif.hit_clear = 4'b0000;
    sof = 1'b0;
    tick(); check("hitsof_mask2", 32'(sif.active_mask), 32'b1101);
    pix(607, 600, 1'b1, 8'hF4, "moved596");
    sif.hit_clear = 4'b1111;
    tick(); check("clr_all", 32'(sif.active_mask), 32'd0);
    sif.hit_clear = 4'b0000;

    // Movement and retire from y=10
    fire(500, 10, 4'b0001, "fire_mv");
    pix(507, 10, 1'b1, 8'hF0, "mv0");
    sof = 1'b1; tick(); sof = 1'b0;
    pix(507, 10, 1'b1, 8'hF4, "mv_y6");
    sof = 1'b1; tick(); sof = 1'b0;
    pix(507, 10, 1'b1, 8'hF8, "mv_y2");
    sof = 1'b1; tick(); sof = 1'b0;
    check("retire_mask", 32'(sif.active_mask), 32'd0);
    pix(507, 10, 1'b0, 8'hFF, "retired");

    // Right-edge boundary, no wrap
    fire(2040, 50, 4'b0001, "fire_edge");
    pix(2047, 50, 1'b1, 8'hF0, "edge2047");
    pix(5, 50, 1'b0, 8'hFF, "nowrap");
    pix(2046, 65, 1'b1, 8'hEF, "edge_bot");
    pix(2047, 49, 1'b0, 8'hFF, "above");
    sif.hit_clear = 4'b0001;
    tick();
    sif.hit_clear = 4'b0000;

    // Reset during an accepting cycle: no ack escapes
    sif.fire_req = 1'b1;
    sif.fire_x = 11'd10;
    sif.fire_y = 11'd10;
    #3 reset = 1'b1;
    #1 check("rstfire_ack", 32'(sif.fire_ack), 32'd0);
    check("rstfire_mask", 32'(sif.active_mask), 32'd0);
    tick();
    check("rstfire_ack2", 32'(sif.fire_ack), 32'd0);
    sif.fire_req = 1'b0;
    reset = 1'b0;
    tick();

`ifdef SHOT_COOLDOWN_EN
    cif.fire_req = 1'b1;
    cif.fire_x = 11'd300;
    cif.fire_y = 11'd300;
    tick(); check("cd_ack1", 32'(cif.fire_ack), 32'd1);
    tick(); check("cd_hold", 32'(cif.fire_ack), 32'd0);
    sof = 1'b1; tick(); sof = 1'b0;
    check("cd_sof1", 32'(cif.fire_ack), 32'd0);
    tick(); check("cd_wait", 32'(cif.fire_ack), 32'd0);
    sof = 1'b1; tick(); sof = 1'b0;
    check("cd_sof2", 32'(cif.fire_ack), 32'd0);
    tick(); check("cd_ack2", 32'(cif.fire_ack), 32'd1);
    check("cd_mask", 32'(cif.active_mask), 32'b0011);
    cif.fire_req = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
